// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - issue/writeback controller driving a combinational ALU from an 8x36 register file (optional: ALU_ISSUE_DIV0_CHECK_EN)
module alu_issue (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_op,
  input  logic [2:0]  cmd_rd,
  input  logic [2:0]  cmd_rs1,
  input  logic [2:0]  cmd_rs2,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [35:0] ld_data,
  output logic [35:0] alu_in1,
  output logic [35:0] alu_in2,
  output logic [4:0]  alu_op,
  input  logic [35:0] alu_out,
  input  logic        alu_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [35:0] rsp_data,
  output logic        rsp_cout,
  output logic        rsp_err
);

  // Opcode encoding shared with the ALU
  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_EQUAL  = 5'd4;
  localparam logic [4:0] OP_DIVIDE = 5'd5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [35:0] rf [0:7];
  logic [2:0]  rd_q;
  logic        op_known;
  logic        div0;
  logic        reject;
  logic        carry_op;
  logic        accept;

  // cmd_ready is gated by reset so nothing is offered while reset_n is low
  assign cmd_ready = reset_n && (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = cmd_valid && cmd_ready;

  // Classify the opcode currently presented to the ALU
  always_comb begin
    op_known = 1'b0;
    carry_op = 1'b0;
    case (alu_op)
      OP_ADD, OP_SUB: begin
        op_known = 1'b1;
        carry_op = 1'b1;
      end
      OP_AND, OP_OR, OP_EQUAL, OP_DIVIDE: op_known = 1'b1;
      default: op_known = 1'b0;
    endcase
  end

`ifdef ALU_ISSUE_DIV0_CHECK_EN
  assign div0 = (alu_op == OP_DIVIDE) && (alu_in2 == 36'd0);
`else
  assign div0 = 1'b0;
`endif

  // A rejected command reports an error and never touches the register file
  assign reject = !op_known || div0;

  // Three-state issue / execute / respond sequence
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state <= EXEC;
        EXEC:    state <= RESP;
        RESP:    if (rsp_valid && rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture on accept; ALU inputs hold their values otherwise
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_op  <= '0;
      rd_q    <= '0;
    end else if (accept) begin
      alu_in1 <= rf[cmd_rs1];
      alu_in2 <= rf[cmd_rs2];
      alu_op  <= cmd_op;
      rd_q    <= cmd_rd;
    end
  end

  // Capture the ALU result at the end of EXEC and hold it through RESP
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_data <= '0;
      rsp_cout <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (state == EXEC) begin
      rsp_err  <= reject;
      rsp_data <= reject ? 36'd0 : alu_out;
      rsp_cout <= (!reject && carry_op) ? alu_cout : 1'b0;
    end
  end

  // Register file: direct loads any cycle; the EXEC writeback is assigned last so it wins a same-index collision
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      if (ld_en) rf[ld_addr] <= ld_data;
      if (state == EXEC && !reject) rf[rd_q] <= alu_out;
    end
  end

endmodule
